// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// FSM states and funct3 access-size codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, byte enables, load extension
// and misaligned/illegal access detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  req_lo,
  input  logic [2:0]  req_size,
  input  logic        req_we,
  input  logic        req_re,
  input  logic [31:0] req_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic        bad,
  input  logic [1:0]  rsp_lo,
  input  logic [2:0]  rsp_size,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] ld_data
);

  logic        illegal;
  logic        misal;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    st_wdata = req_data;
    st_be    = 4'b1111;
    case (req_size[1:0])
      2'b00: begin
        st_wdata = {4{req_data[7:0]}};
        st_be    = 4'b0001 << req_lo;
      end
      2'b01: begin
        st_wdata = {2{req_data[15:0]}};
        st_be    = 4'b0011 << req_lo;
      end
      default: ;
    endcase
  end

  // A store has no unsigned variant; 011/11x are unused codes.
  always_comb begin
    illegal = (req_size == 3'b011)
            | (req_size[2:1] == 2'b11)
            | (req_we & req_size[2]);
    misal   = ((req_size[1:0] == 2'b01) & req_lo[0])
            | ((req_size[1:0] == 2'b10) & (req_lo != 2'b00));
    bad     = (req_we | req_re) & (illegal | misal);
  end

  always_comb begin
    byte_v  = rsp_rdata[8*rsp_lo +: 8];
    half_v  = rsp_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    ld_data = rsp_rdata;
    case (rsp_size)
      LSU_B:   ld_data = {{24{byte_v[7]}}, byte_v};
      LSU_BU:  ld_data = {24'h0, byte_v};
      LSU_H:   ld_data = {{16{half_v[15]}}, half_v};
      LSU_HU:  ld_data = {16'h0, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between EX and EX/MEM: runs one
// req/gnt/rvalid bus access and stalls the front end.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [2:0]        mem_size_i,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_wen_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_wen_o,
  output logic              hold_flag_o,
  output logic              misalign_o
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] data_q;
  logic              kill_q;

  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_be;
  logic              bad;
  logic [DATA_W-1:0] ld_data;
  logic              op;
  logic              accept;

  assign op = mem_we_i | mem_re_i;

  lsu_align u_align (
    .req_lo    (mem_addr_i[1:0]),
    .req_size  (mem_size_i),
    .req_we    (mem_we_i),
    .req_re    (mem_re_i),
    .req_data  (mem_data_i),
    .st_wdata  (st_wdata),
    .st_be     (st_be),
    .bad       (bad),
    .rsp_lo    (addr_q[1:0]),
    .rsp_size  (size_q),
    .rsp_rdata (bus_rdata_i),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= mem_addr_i;
        size_q  <= mem_size_i;
        we_q    <= mem_we_i;
        wdata_q <= st_wdata;
        be_q    <= st_be;
        rd_q    <= rd_addr_i;
        kill_q  <= 1'b0;
      end
      // A flush in WAIT lets the bus finish but drops the writeback.
      if (state_q == WAIT && flush_i)
        kill_q <= 1'b1;
      if (state_q == WAIT && bus_rvalid_i)
        data_q <= ld_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_be_o    = '0;
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    hold_flag_o = 1'b0;
    misalign_o  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          rd_addr_o = rd_addr_i;
          if (!op) begin
            rd_data_o = rd_data_i;
            rd_wen_o  = rd_wen_i;
          end else if (bad) begin
            misalign_o = 1'b1;
          end else begin
            hold_flag_o = 1'b1;
            accept      = 1'b1;
            state_d     = REQ;
          end
        end
        REQ: begin
          // Request is withdrawn in the flush cycle so no
          // grant can be taken for an abandoned access.
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            bus_req_o   = 1'b1;
            bus_we_o    = we_q;
            bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
            bus_wdata_o = wdata_q;
            bus_be_o    = be_q;
            hold_flag_o = 1'b1;
            if (bus_gnt_i)
              state_d = we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          hold_flag_o = 1'b1;
          if (bus_rvalid_i)
            state_d = DONE;
        end
        DONE: begin
          rd_addr_o = rd_q;
          rd_wen_o  = ~we_q & ~kill_q;
          rd_data_o = we_q ? '0 : data_q;
          state_d   = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a
// transaction-level model of the access rules.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [2:0]  mem_size_i;
  logic        mem_we_i, mem_re_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_wen_i, flush_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o, hold_flag_o, misalign_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_size_i   (mem_size_i),
    .mem_we_i     (mem_we_i),
    .mem_re_i     (mem_re_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_i    (rd_data_i),
    .rd_wen_i     (rd_wen_i),
    .flush_i      (flush_i),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o),
    .rd_wen_o     (rd_wen_o),
    .hold_flag_o  (hold_flag_o),
    .misalign_o   (misalign_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    return 1 << sz[1:0];
  endfunction

  function automatic logic bad_m(input logic [31:0] a,
                                 input logic [2:0] sz,
                                 input logic we, input logic re);
    logic legal;
    if (!(we || re)) return 1'b0;
    if (we) legal = (sz <= 3'd2);
    else    legal = (sz <= 3'd2) || (sz == 3'd4) || (sz == 3'd5);
    if (!legal) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] wdata_m(input logic [31:0] d,
                                          input logic [2:0] sz);
    case (nbytes(sz))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] be_m(input logic [31:0] a,
                                       input logic [2:0] sz);
    int n;
    n = nbytes(sz);
    return ((32'd1 << n) - 1) << (a % 4);
  endfunction

  function automatic logic [31:0] ld_m(input logic [31:0] rdat,
                                       input logic [31:0] a,
                                       input logic [2:0] sz);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = rdat >> (8 * (a % 4));
    if (n < 4) begin
      v = v & ((32'd1 << (8 * n)) - 1);
      if (!sz[2] && v >= (32'd1 << (8 * n - 1)))
        v = v - (32'd1 << (8 * n));
    end
    return v;
  endfunction

  task automatic idle_in;
    mem_addr_i   = $urandom;
    mem_data_i   = $urandom;
    mem_size_i   = 3'($urandom);
    mem_we_i     = 1'b0;
    mem_re_i     = 1'b0;
    rd_addr_i    = 5'($urandom);
    rd_data_i    = $urandom;
    rd_wen_i     = 1'($urandom);
    flush_i      = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = $urandom;
  endtask

  task automatic junk_in;
    mem_addr_i   = $urandom;
    mem_data_i   = $urandom;
    mem_size_i   = 3'($urandom);
    mem_we_i     = 1'($urandom);
    mem_re_i     = 1'($urandom);
    rd_addr_i    = 5'($urandom);
    rd_data_i    = $urandom;
    rd_wen_i     = 1'($urandom);
    flush_i      = 1'b0;
    bus_gnt_i    = 1'($urandom);
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = $urandom;
  endtask

  // fl: 0 none, 1 flush in REQ instead of gnt, 2 flush in WAIT
  task automatic run_op(input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz,
                        input logic we, input logic re,
                        input int gd, input int rdly, input int fl,
                        input logic [31:0] rdat);
    logic [4:0]  rd;
    logic [31:0] rdd;
    logic        isld;
    rd  = 5'($urandom);
    rdd = $urandom;
    mem_addr_i = a; mem_data_i = d; mem_size_i = sz;
    mem_we_i = we; mem_re_i = re;
    rd_addr_i = rd; rd_data_i = rdd; rd_wen_i = 1'b1;
    flush_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    #1;
    if (!(we || re)) begin
      chk("pass_data", rd_data_o, rdd);
      chk("pass_rd", 32'(rd_addr_o), 32'(rd));
      chk("pass_wen", 32'(rd_wen_o), 1);
      chk("pass_hold", 32'(hold_flag_o), 0);
      chk("pass_req", 32'(bus_req_o), 0);
      step;
      return;
    end
    if (bad_m(a, sz, we, re)) begin
      chk("mis_pulse", 32'(misalign_o), 1);
      chk("mis_req", 32'(bus_req_o), 0);
      chk("mis_hold", 32'(hold_flag_o), 0);
      chk("mis_wen", 32'(rd_wen_o), 0);
      step;
      idle_in;
      #1;
      chk("mis_width", 32'(misalign_o), 0);
      chk("mis_req2", 32'(bus_req_o), 0);
      step;
      return;
    end
    isld = !we;
    chk("acc_hold", 32'(hold_flag_o), 1);
    chk("acc_req", 32'(bus_req_o), 0);
    chk("acc_mis", 32'(misalign_o), 0);
    chk("acc_wen", 32'(rd_wen_o), 0);
    step;
    for (int k = 0; k <= gd; k++) begin
      junk_in;
      if (fl == 1 && k == gd) begin
        flush_i = 1'b1;
        bus_gnt_i = 1'b0;
        #1;
        chk("fl_hold", 32'(hold_flag_o), 0);
        step;
        idle_in;
        #1;
        chk("fl_req", 32'(bus_req_o), 0);
        chk("fl_hold2", 32'(hold_flag_o), 0);
        chk("fl_pass", 32'(rd_wen_o), 32'(rd_wen_i));
        step;
        return;
      end
      bus_gnt_i = (k == gd);
      #1;
      chk("req_req", 32'(bus_req_o), 1);
      chk("req_addr", bus_addr_o, a & ~32'h3);
      chk("req_we", 32'(bus_we_o), 32'(we));
      chk("req_hold", 32'(hold_flag_o), 1);
      chk("req_mis", 32'(misalign_o), 0);
      if (we) begin
        chk("req_wdata", bus_wdata_o, wdata_m(d, sz));
        chk("req_be", 32'(bus_be_o), be_m(a, sz));
      end
      step;
    end
    if (isld) begin
      for (int k = 0; k <= rdly; k++) begin
        junk_in;
        bus_rvalid_i = (k == rdly);
        if (k == rdly) bus_rdata_i = rdat;
        flush_i = (fl == 2 && k == 0);
        #1;
        chk("wait_hold", 32'(hold_flag_o), 1);
        chk("wait_req", 32'(bus_req_o), 0);
        chk("wait_wen", 32'(rd_wen_o), 0);
        step;
      end
    end
    junk_in;
    #1;
    chk("done_hold", 32'(hold_flag_o), 0);
    chk("done_req", 32'(bus_req_o), 0);
    chk("done_wen", 32'(rd_wen_o), 32'(isld && fl != 2));
    chk("done_rd", 32'(rd_addr_o), 32'(rd));
    chk("done_data", rd_data_o, isld ? ld_m(rdat, a, sz) : 32'h0);
    step;
    idle_in;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {18'h0, bus_req_o, bus_we_o, bus_be_o,
        rd_wen_o, hold_flag_o, misalign_o, rd_addr_o}, 0);
    chk({tag, "_addr"}, bus_addr_o, 0);
    chk({tag, "_wdata"}, bus_wdata_o, 0);
    chk({tag, "_rdata"}, rd_data_o, 0);
  endtask

  initial begin
    logic [2:0]  sz;
    logic        we, re;
    int          kind;
    rst = 1'b1;
    junk_in;
    mem_re_i = 1'b1;
    rd_wen_i = 1'b1;
    step;
    step;
    chk_zero("rst");
    rst = 1'b0;
    idle_in;
    step;

    run_op(32'h1003, 32'hAABBCC5A, LSU_B, 1, 0, 0, 0, 0, 0);
    run_op(32'h2001, 0, LSU_B,  0, 1, 0, 0, 0, 32'h1234F678);
    run_op(32'h2001, 0, LSU_BU, 0, 1, 0, 0, 0, 32'h1234F678);
    run_op(32'h2002, 0, LSU_H,  0, 1, 0, 0, 0, 32'h1234F678);
    run_op(32'h2000, 0, LSU_HU, 0, 1, 0, 0, 0, 32'h1234F678);
    run_op(32'h3000, 0, LSU_W,  0, 1, 3, 2, 0, 32'hCAFEF00D);
    run_op(32'h3002, 0, LSU_W,  0, 1, 0, 0, 0, 0);
    run_op(32'h3001, 32'h1234, LSU_H, 1, 0, 0, 0, 0, 0);
    run_op(32'h3100, 0, LSU_W,  0, 1, 1, 0, 1, 0);
    run_op(32'h3104, 0, LSU_W,  0, 1, 0, 2, 2, 32'h87654321);
    run_op(32'h3106, 32'hBEEF, LSU_H, 1, 1, 0, 0, 0, 0);

    // Reset while waiting for read data
    mem_addr_i = 32'h4000; mem_size_i = LSU_W;
    mem_we_i = 1'b0; mem_re_i = 1'b1;
    rd_addr_i = 5'd9; rd_wen_i = 1'b1;
    step;
    bus_gnt_i = 1'b1;
    step;
    bus_gnt_i = 1'b0;
    rst = 1'b1;
    step;
    chk_zero("rst_wait");
    rst = 1'b0;
    idle_in;
    rd_addr_i = 5'd3; rd_data_i = 32'h55; rd_wen_i = 1'b1;
    bus_rvalid_i = 1'b1;
    #1;
    chk("add_data", rd_data_o, 32'h55);
    chk("add_wen", 32'(rd_wen_o), 1);
    chk("add_hold", 32'(hold_flag_o), 0);
    step;
    bus_rvalid_i = 1'b0;
    #1;
    chk("late_rv_data", rd_data_o, 32'h55);
    chk("late_rv_rd", 32'(rd_addr_o), 3);
    step;

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      sz = 3'($urandom);
      if (kind < 2) begin
        we = 1'b0; re = 1'b0;
      end else begin
        we = 1'($urandom); re = 1'($urandom);
        if (!we && !re) re = 1'b1;
      end
      run_op($urandom, $urandom, sz, we, re,
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? 1 :
             ($urandom_range(0, 9) == 0) ? 2 : 0,
             $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
